// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus: program-load byte stream plus the core-facing fetch port.
// slave = fetch unit, master = byte source / core.
interface instr_fetch_unit_if;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_byte;
    logic        load_last;
    logic [1:0]  pc_source;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] instruction_out;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        fetch_fault;
    logic [1:0]  state;

    modport slave (
        input  load_valid, load_byte, load_last,
        input  pc_source, branch_offset, jump_target, stall,
        output load_ready, instruction_out, pc, pc_plus4,
        output instr_valid, fetch_fault, state
    );

    modport master (
        output load_valid, load_byte, load_last,
        output pc_source, branch_offset, jump_target, stall,
        input  load_ready, instruction_out, pc, pc_plus4,
        input  instr_valid, fetch_fault, state
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loads a program from a byte stream, then serves one
// instruction per cycle at pc. Ports: clk, rst (sync, active-high), bus (slave).
module instr_fetch_unit #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    instr_fetch_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_pc;
    logic [31:0]       w_pc_nxt;
    logic [31:0]       w_next_pc;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_word_ptr;
    logic [ADDR_W:0]   r_words_loaded;
    logic              r_fault;
    logic              w_fault_set;
    logic [31:0]       r_asm;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_xfer;
    logic              w_word_wr;
    logic [31:0]       w_byte_sh;
    logic [31:0]       w_wdata;
    logic [31:0]       w_mem_rd;
    logic [31:0]       w_instr;
    logic              w_oob;
    logic              w_misalign;

    // Load datapath: earlier bytes of the word sit in r_asm, the current byte
    // is merged in at its lane, and untouched upper lanes stay zero.
    assign w_xfer    = bus.load_valid && (r_state == S_LOAD);
    assign w_word_wr = w_xfer && ((r_byte_cnt == 2'd3) || bus.load_last);
    assign w_byte_sh = {24'h0, bus.load_byte} << {r_byte_cnt, 3'b000};
    assign w_wdata   = r_asm | w_byte_sh;

    // Zero-latency read so the core executes the instruction in this cycle.
    assign w_mem_rd = r_mem[r_pc[ADDR_W+1:2]];
    assign w_instr  = (r_state == S_RUN) ? w_mem_rd : NOP;

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (bus.pc_source)
            2'b01:   w_next_pc = r_pc + bus.branch_offset;
            2'b10:   w_next_pc = bus.jump_target & ~32'h1;
            default: w_next_pc = r_pc + 32'd4;
        endcase
    end

    assign w_misalign = (w_next_pc[1:0] != 2'b00);
    assign w_oob = w_next_pc[31:2] >= {{(29-ADDR_W){1'b0}}, r_words_loaded};

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_set = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_word_wr && (bus.load_last ||
                    (r_word_ptr == ADDR_W'(DEPTH_WORDS-1))))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!bus.stall) begin
                    if (w_instr == EBREAK) begin
                        w_state_nxt = S_HALT;
                    end else if (w_misalign || w_oob) begin
                        w_state_nxt = S_HALT;
                        w_fault_set = 1'b1;
                    end else begin
                        w_pc_nxt = w_next_pc;
                    end
                end
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_LOAD;
            r_pc           <= RESET_PC;
            r_byte_cnt     <= 2'd0;
            r_word_ptr     <= '0;
            r_words_loaded <= '0;
            r_fault        <= 1'b0;
            r_asm          <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_fault_set)
                r_fault <= 1'b1;
            if (w_xfer) begin
                if (w_word_wr) begin
                    r_asm          <= 32'h0;
                    r_byte_cnt     <= 2'd0;
                    r_word_ptr     <= r_word_ptr + 1'b1;
                    r_words_loaded <= {1'b0, r_word_ptr} + {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    r_asm      <= w_wdata;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                end
            end
        end
    end

    // Program memory survives reset so a reload can overwrite only a prefix.
    always_ff @(posedge clk) begin
        if (!rst && w_word_wr)
            r_mem[r_word_ptr] <= w_wdata;
    end

    assign bus.load_ready      = (r_state == S_LOAD);
    assign bus.instruction_out = w_instr;
    assign bus.pc              = r_pc;
    assign bus.pc_plus4        = r_pc + 32'd4;
    assign bus.instr_valid     = (r_state == S_RUN);
    assign bus.fetch_fault     = r_fault;
    assign bus.state           = r_state;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: table of RUN-mode next-PC vectors
// plus directed load / halt / fault / reset sequences.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  src;
        logic [31:0] off;
        logic [31:0] jt;
        logic        stall;
        logic [31:0] exp_pc;
        logic [1:0]  exp_st;
        logic        exp_fault;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        bus.load_last  = last;
        @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], last && (k == 3));
    endtask

    task automatic load_nops(input int n);
        for (int i = 0; i < n; i++)
            send_word(32'h0000_0013, i == n-1);
    endtask

    task automatic step(input logic [1:0] src, input logic [31:0] off,
                        input logic [31:0] jt, input logic stl);
        @(negedge clk);
        bus.pc_source     = src;
        bus.branch_offset = off;
        bus.jump_target   = jt;
        bus.stall         = stl;
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
    endtask

    initial begin
        logic [31:0] mpc;
        bus.load_valid    = 1'b0;
        bus.load_byte     = 8'h00;
        bus.load_last     = 1'b0;
        bus.pc_source     = 2'b00;
        bus.branch_offset = 32'h0;
        bus.jump_target   = 32'h0;
        bus.stall         = 1'b0;

        vt[0] = '{2'b00, 32'h0,         32'h0,  1'b0, 32'd4,  2'b01, 1'b0};
        vt[1] = '{2'b11, 32'h0,         32'h0,  1'b0, 32'd8,  2'b01, 1'b0};
        vt[2] = '{2'b01, 32'd8,         32'h0,  1'b0, 32'd16, 2'b01, 1'b0};
        vt[3] = '{2'b01, 32'hFFFF_FFF0, 32'h0,  1'b0, 32'd0,  2'b01, 1'b0};
        vt[4] = '{2'b10, 32'h0,         32'h15, 1'b0, 32'd20, 2'b01, 1'b0};
        vt[5] = '{2'b00, 32'h0,         32'h0,  1'b1, 32'd20, 2'b01, 1'b0};
        vt[6] = '{2'b01, 32'd8,         32'h0,  1'b0, 32'd28, 2'b01, 1'b0};
        vt[7] = '{2'b00, 32'h0,         32'h0,  1'b0, 32'd28, 2'b10, 1'b1};

        // Reset state
        do_reset();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_ivalid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instruction_out, 32'h0000_0013);
        chk("rst_fault", 32'(bus.fetch_fault), 32'd0);

        // Two-word program, little-endian byte order
        send_word(32'h0050_0013, 1'b0);
        send_word(32'h0010_0093, 1'b1);
        chk("t1_state", 32'(bus.state), 32'd1);
        chk("t1_pc0", bus.pc, 32'd0);
        chk("t1_instr0", bus.instruction_out, 32'h0050_0013);
        chk("t1_pc4", bus.pc_plus4, 32'd4);
        chk("t1_ivalid", 32'(bus.instr_valid), 32'd1);
        chk("t1_ready", 32'(bus.load_ready), 32'd0);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t1_pc1", bus.pc, 32'd4);
        chk("t1_instr1", bus.instruction_out, 32'h0010_0093);

        // EBREAK with partial final word
        do_reset();
        send_byte(8'h73, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b1);
        chk("t2_state_run", 32'(bus.state), 32'd1);
        chk("t2_instr", bus.instruction_out, 32'h0010_0073);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t2_state_halt", 32'(bus.state), 32'd2);
        chk("t2_pc", bus.pc, 32'd0);
        chk("t2_fault", 32'(bus.fetch_fault), 32'd0);
        chk("t2_ivalid", 32'(bus.instr_valid), 32'd0);
        chk("t2_nop", bus.instruction_out, 32'h0000_0013);
        send_byte(8'hAA, 1'b1);
        chk("t2_halt_hold", 32'(bus.state), 32'd2);
        chk("t2_halt_ready", 32'(bus.load_ready), 32'd0);

        // Table-driven next-PC selection over 8 NOP words
        do_reset();
        load_nops(8);
        mpc = 32'd0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("v%0d_pre_instr", i), bus.instruction_out, 32'h13);
            chk($sformatf("v%0d_pre_p4", i), bus.pc_plus4, mpc + 32'd4);
            step(vt[i].src, vt[i].off, vt[i].jt, vt[i].stall);
            chk($sformatf("v%0d_pc", i), bus.pc, vt[i].exp_pc);
            chk($sformatf("v%0d_state", i), 32'(bus.state), 32'(vt[i].exp_st));
            chk($sformatf("v%0d_fault", i), 32'(bus.fetch_fault),
                32'(vt[i].exp_fault));
            mpc = vt[i].exp_pc;
        end

        // Misaligned jump target after masking bit 0
        do_reset();
        load_nops(4);
        step(2'b10, 32'h0, 32'h7, 1'b0);
        chk("t4_state", 32'(bus.state), 32'd2);
        chk("t4_fault", 32'(bus.fetch_fault), 32'd1);
        chk("t4_pc", bus.pc, 32'd0);

        // Out-of-range fall-through, delayed by stall
        do_reset();
        load_nops(2);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t5_pc4", bus.pc, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 32'h0, 32'h0, 1'b1);
            chk($sformatf("t5_stall%0d_pc", i), bus.pc, 32'd4);
            chk($sformatf("t5_stall%0d_st", i), 32'(bus.state), 32'd1);
        end
        chk("t5_nofault", 32'(bus.fetch_fault), 32'd0);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t5_state", 32'(bus.state), 32'd2);
        chk("t5_fault", 32'(bus.fetch_fault), 32'd1);
        chk("t5_pc", bus.pc, 32'd4);

        // Mid-run reset and partial reload
        do_reset();
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0013, 1'b0);
        send_word(32'h0000_0013, 1'b1);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t6_pc8", bus.pc, 32'd8);
        do_reset();
        chk("t6_rst_state", 32'(bus.state), 32'd0);
        chk("t6_rst_pc", bus.pc, 32'd0);
        chk("t6_rst_ready", 32'(bus.load_ready), 32'd1);
        chk("t6_rst_fault", 32'(bus.fetch_fault), 32'd0);
        send_word(32'h0020_0093, 1'b1);
        chk("t6_instr", bus.instruction_out, 32'h0020_0093);
        chk("t6_mem1", dut.r_mem[1], 32'h0010_0013);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t6_state", 32'(bus.state), 32'd2);
        chk("t6_fault", 32'(bus.fetch_fault), 32'd1);
        chk("t6_pc", bus.pc, 32'd0);

        // Memory full ends loading without load_last
        do_reset();
        for (int i = 0; i < 256; i++)
            send_word({24'h0, 8'(i)}, 1'b0);
        chk("t7_state", 32'(bus.state), 32'd1);
        chk("t7_ready", 32'(bus.load_ready), 32'd0);
        chk("t7_instr0", bus.instruction_out, 32'h0);
        @(negedge clk);
        bus.stall = 1'b1;
        send_byte(8'h55, 1'b1);
        bus.stall = 1'b0;
        chk("t7_extra_state", 32'(bus.state), 32'd1);
        chk("t7_mem0", dut.r_mem[0], 32'h0);
        step(2'b10, 32'h0, 32'd1020, 1'b0);
        chk("t7_pc_top", bus.pc, 32'd1020);
        chk("t7_instr_top", bus.instruction_out, 32'h0000_00FF);
        step(2'b00, 32'h0, 32'h0, 1'b0);
        chk("t7_end_state", 32'(bus.state), 32'd2);
        chk("t7_end_fault", 32'(bus.fetch_fault), 32'd1);
        chk("t7_end_pc", bus.pc, 32'd1020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
